// File: rtl/verificador_pkg.sv
// Shared types and default constants for the attempt verifier that sits
// behind the equality comparator.
package verificador_pkg;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        ESPERA   = 3'd1,
        EVALUA   = 3'd2,
        BLOQUEO  = 3'd3,
        GANO     = 3'd4,
        PERDIO   = 3'd5
    } estado_t;

    localparam int MAX_INTENTOS_DEF = 3;
    localparam int W_CNT_DEF        = 3;
    localparam int T_BLOQUEO_DEF    = 16;
    localparam int W_TMR_DEF        = 5;

endpackage

// File: rtl/temporizador_bloqueo.sv
// Loadable lockout down-counter. fin is high in the cycle the running
// count sits at zero; the timer stops itself after that cycle.
module temporizador_bloqueo #(
    parameter int W_TMR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cargar,
    input  logic             limpiar,
    input  logic [W_TMR-1:0] valor,
    output logic             fin
);

    logic [W_TMR-1:0] cuenta;
    logic             activo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= '0;
            activo <= 1'b0;
        end else if (limpiar) begin
            cuenta <= '0;
            activo <= 1'b0;
        end else if (cargar) begin
            cuenta <= valor;
            activo <= 1'b1;
        end else if (activo) begin
            if (cuenta == '0) begin
                activo <= 1'b0;
            end else begin
                cuenta <= cuenta - 1'b1;
            end
        end
    end

    assign fin = activo && (cuenta == '0);

endmodule

// File: rtl/verificador_intentos.sv
// Samples the comparator flag on each submit, counts failures, enforces a
// lockout after each miss and reports win/loss. estado exposes the FSM.
module verificador_intentos
    import verificador_pkg::*;
#(
    parameter int MAX_INTENTOS = MAX_INTENTOS_DEF,
    parameter int W_CNT        = W_CNT_DEF,
    parameter int T_BLOQUEO    = T_BLOQUEO_DEF,
    parameter int W_TMR        = W_TMR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic             probar,
    input  logic             iguales,
    output logic             listo,
    output logic             acierto,
    output logic             perdio,
    output logic             bloqueado,
    output logic             evento_fallo,
    output logic [W_CNT-1:0] intentos_restantes,
    output logic [2:0]       estado
);

    localparam logic [W_CNT-1:0] CARGA_INTENTOS = W_CNT'(MAX_INTENTOS);
    localparam logic [W_TMR-1:0] CARGA_TMR      = W_TMR'(T_BLOQUEO - 1);

    estado_t          estado_q, estado_d;
    logic [W_CNT-1:0] intentos_q, intentos_d;
    logic             flag_q, flag_d;
    logic             evento_q, evento_d;
    logic             cargar_tmr, limpiar_tmr, fin_tmr;

    temporizador_bloqueo #(
        .W_TMR (W_TMR)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .cargar  (cargar_tmr),
        .limpiar (limpiar_tmr),
        .valor   (CARGA_TMR),
        .fin     (fin_tmr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= INACTIVO;
            intentos_q <= '0;
            flag_q     <= 1'b0;
            evento_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            intentos_q <= intentos_d;
            flag_q     <= flag_d;
            evento_q   <= evento_d;
        end
    end

    // iniciar overrides everything, so a guess arriving with it is dropped.
    always_comb begin
        estado_d    = estado_q;
        intentos_d  = intentos_q;
        flag_d      = flag_q;
        evento_d    = 1'b0;
        cargar_tmr  = 1'b0;
        limpiar_tmr = 1'b0;
        if (iniciar) begin
            estado_d    = ESPERA;
            intentos_d  = CARGA_INTENTOS;
            flag_d      = 1'b0;
            limpiar_tmr = 1'b1;
        end else begin
            case (estado_q)
                INACTIVO: estado_d = INACTIVO;
                ESPERA: begin
                    if (probar) begin
                        flag_d   = iguales;
                        estado_d = EVALUA;
                    end
                end
                EVALUA: begin
                    if (flag_q) begin
                        estado_d = GANO;
                    end else begin
                        evento_d = 1'b1;
                        if (intentos_q != '0) begin
                            intentos_d = intentos_q - 1'b1;
                        end
                        // Last attempt goes straight to loss without a lockout.
                        if (intentos_q <= W_CNT'(1)) begin
                            estado_d = PERDIO;
                        end else begin
                            estado_d   = BLOQUEO;
                            cargar_tmr = 1'b1;
                        end
                    end
                end
                BLOQUEO: begin
                    if (fin_tmr) begin
                        estado_d = ESPERA;
                    end
                end
                GANO:     estado_d = GANO;
                PERDIO:   estado_d = PERDIO;
                default:  estado_d = INACTIVO;
            endcase
        end
    end

    assign listo              = (estado_q == ESPERA);
    assign acierto            = (estado_q == GANO);
    assign perdio             = (estado_q == PERDIO);
    assign bloqueado          = (estado_q == BLOQUEO);
    assign evento_fallo       = evento_q;
    assign intentos_restantes = intentos_q;
    assign estado             = estado_q;

endmodule

// File: tb/tb_verificador_intentos.sv
// Directed bench for verificador_intentos: win, fail/lockout, loss,
// restart priority and asynchronous reset.
module tb_verificador_intentos;
    import verificador_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iniciar = 1'b0;
    logic       probar = 1'b0;
    logic       iguales = 1'b0;
    logic       listo, acierto, perdio, bloqueado, evento_fallo;
    logic [2:0] intentos_restantes;
    logic [2:0] estado;

    int n_cmp = 0;
    int n_err = 0;
    int ciclos;
    int n_bloq;
    logic ev_visto;

    verificador_intentos dut (
        .clk                (clk),
        .rst                (rst),
        .iniciar            (iniciar),
        .probar             (probar),
        .iguales            (iguales),
        .listo              (listo),
        .acierto            (acierto),
        .perdio             (perdio),
        .bloqueado          (bloqueado),
        .evento_fallo       (evento_fallo),
        .intentos_restantes (intentos_restantes),
        .estado             (estado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags = {listo, acierto, perdio, bloqueado, evento_fallo}
    task automatic chk_all(input string tag, input estado_t e, input logic [4:0] flags,
                           input logic [2:0] cnt);
        chk({tag, ".estado"}, 32'(estado), 32'(e));
        chk({tag, ".flags"}, 32'({listo, acierto, perdio, bloqueado, evento_fallo}), 32'(flags));
        chk({tag, ".cnt"}, 32'(intentos_restantes), 32'(cnt));
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic intento(input logic igual);
        probar  = 1'b1;
        iguales = igual;
        tick();
        probar  = 1'b0;
        tick();
    endtask

    task automatic esperar_listo(input int limite, output int n);
        n = 0;
        while (!listo && n < limite) begin
            tick();
            n++;
        end
    endtask

    initial begin
        // 1: async reset with no clock edge, then start
        #3 rst = 1'b1;
        #1 chk_all("reset_async", INACTIVO, 5'b00000, 3'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all("idle", INACTIVO, 5'b00000, 3'd0);
        probar = 1'b1; iguales = 1'b1;
        tick();
        probar = 1'b0;
        chk_all("idle_probar_ignored", INACTIVO, 5'b00000, 3'd0);
        pulso_iniciar();
        chk_all("start", ESPERA, 5'b10000, 3'd3);

        // 2: correct guess
        probar = 1'b1; iguales = 1'b1;
        tick();
        probar = 1'b0;
        chk_all("win_evalua", EVALUA, 5'b00000, 3'd3);
        tick();
        chk_all("win", GANO, 5'b01000, 3'd3);
        tick();
        chk_all("win_hold", GANO, 5'b01000, 3'd3);

        // 3: failed guess, lockout of exactly 16 cycles, probar ignored inside
        pulso_iniciar();
        chk_all("restart", ESPERA, 5'b10000, 3'd3);
        intento(1'b0);
        chk_all("fail1", BLOQUEO, 5'b00011, 3'd2);
        n_bloq = 1;
        ev_visto = 1'b0;
        for (int i = 0; i < 40; i++) begin
            probar  = (i == 3);
            iguales = 1'b1;
            tick();
            ev_visto = ev_visto | evento_fallo;
            if (!bloqueado) break;
            n_bloq++;
        end
        probar = 1'b0;
        chk("lock_len", 32'(n_bloq), 32'd16);
        chk("lock_evento_once", 32'(ev_visto), 32'd0);
        chk_all("after_lock", ESPERA, 5'b10000, 3'd2);
        tick();
        chk_all("after_lock_no_queue", ESPERA, 5'b10000, 3'd2);

        // 4: three misses -> loss, no lockout on the last one
        pulso_iniciar();
        intento(1'b0);
        chk_all("loss_f1", BLOQUEO, 5'b00011, 3'd2);
        esperar_listo(40, ciclos);
        chk("loss_lock1", 32'(ciclos), 32'd16);
        intento(1'b0);
        chk_all("loss_f2", BLOQUEO, 5'b00011, 3'd1);
        esperar_listo(40, ciclos);
        chk("loss_lock2", 32'(ciclos), 32'd16);
        intento(1'b0);
        chk_all("loss_f3", PERDIO, 5'b00101, 3'd0);
        intento(1'b1);
        chk_all("loss_hold", PERDIO, 5'b00100, 3'd0);
        pulso_iniciar();
        chk_all("loss_restart", ESPERA, 5'b10000, 3'd3);

        // 5: iniciar beats probar; iniciar inside EVALUA and BLOQUEO
        iniciar = 1'b1; probar = 1'b1; iguales = 1'b1;
        tick();
        iniciar = 1'b0; probar = 1'b0;
        chk_all("ini_probar", ESPERA, 5'b10000, 3'd3);
        tick();
        chk_all("ini_probar_next", ESPERA, 5'b10000, 3'd3);
        probar = 1'b1; iguales = 1'b0;
        tick();
        probar = 1'b0;
        pulso_iniciar();
        chk_all("ini_in_evalua", ESPERA, 5'b10000, 3'd3);
        intento(1'b0);
        tick();
        tick();
        tick();
        chk_all("mid_lock", BLOQUEO, 5'b00010, 3'd2);
        pulso_iniciar();
        chk_all("ini_in_lock", ESPERA, 5'b10000, 3'd3);
        for (int i = 0; i < 20; i++) tick();
        chk_all("ini_in_lock_stays", ESPERA, 5'b10000, 3'd3);

        // 6: async reset in EVALUA after a miss cancels the pending pulse
        probar = 1'b1; iguales = 1'b0;
        tick();
        probar = 1'b0;
        chk_all("pre_rst_evalua", EVALUA, 5'b00000, 3'd3);
        #2 rst = 1'b1;
        #1 chk_all("rst_mid_evalua", INACTIVO, 5'b00000, 3'd0);
        tick();
        chk_all("rst_held", INACTIVO, 5'b00000, 3'd0);
        rst = 1'b0;
        tick();
        chk_all("rst_release", INACTIVO, 5'b00000, 3'd0);
        pulso_iniciar();
        chk_all("rst_recover", ESPERA, 5'b10000, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
